regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
Arbitrates one single-port 128x8 synchronous register RAM among N_REQ requesters. Port 0 is the SPI host path; ports 1..N_REQ-1 are motor-side sequencers, such as the channel state walker and a future status/IRQ scanner. Port 0 has fixed priority, the other ports share round-robin, and a starvation guard keeps them from being locked out. A lock mechanism gives atomic multi-byte access so 24-bit positions are never torn.

Parameters:
N_REQ, 3, number of requesters (2..8); port 0 = host
ADDR_W, 7, register address width
DATA_W, 8, register data width
STARVE_LIMIT, 12, consecutive cycles a waiting low port may lose to the host before it is forced through
LOCK_MAX, 64, maximum cycles a lock may be held before forced release

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  N_REQ  request pending, per port
req_we  in  N_REQ  1=write, 0=read
req_lock  in  N_REQ  hold ownership after this access
req_addr  in  N_REQ*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  port i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  grant; accept = valid && ready at a rising edge
rsp_valid  out  N_REQ  one-hot read-data strobe
rsp_data  out  DATA_W  read data, qualified by rsp_valid
mem_en  out  1  memory access strobe (registered)
mem_we  out  1  memory write enable (registered)
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en
lock_abort  out  1  sticky: a lock hit LOCK_MAX
lock_owner  out  4  owner index, 4'hF = unlocked

Behaviour:
- Reset values:
  - req_ready, rsp_valid, mem_en, mem_we: 0. mem_addr, mem_wdata: 0.
  - lock_abort: 0. lock_owner: F.
  - rr pointer: port 1. starve counter: 0. lock timer: 0.
- Reset during a pending read drops the response: rsp_valid stays 0.
- Handshake:
  - A requester holds valid, we, addr, wdata and lock stable until accepted.
  - req_ready is combinational from req_valid and registered state.
  - At most one bit of req_ready is high per cycle.
  - Back-to-back accepts are allowed every cycle.
- Grant selection, evaluated each cycle, first match wins:
  1. Lock held:
     - Grant the owner if req_valid[owner]. Otherwise grant nobody.
  2. Unlocked, some low port valid and starve counter >= STARVE_LIMIT:
     - Grant the round-robin pick.
  3. Unlocked, req_valid[0]:
     - Grant port 0.
  4. Otherwise:
     - Round-robin among ports 1..N_REQ-1, searching from rr pointer upward with wrap, skipping port 0.
- The rr pointer moves to the port after the granted low port (wrapping N_REQ-1 -> 1). A host grant leaves it unchanged.
- Starve counter:
  - Increments (saturating) when any low port is valid, no lock is held, and the host is granted.
  - Clears on any low-port accept.
  - Holds otherwise.
- Pipeline, for an accept at edge T:
  - mem_en, mem_we, mem_addr, mem_wdata are driven during cycle T..T+1.
  - The memory samples at edge T+1.
  - For a read, rsp_valid[i]=1 and rsp_data=mem_rdata during cycle T+1..T+2.
  - Read latency is 2 edges. Writes produce no rsp_valid.
- Lock:
  - Accepting a request with req_lock=1 sets lock_owner=i and clears the lock timer.
  - The owner releases by:
    - an accepted request with req_lock=0, which is granted, then released at the same edge; or
    - deasserting req_lock while req_valid is low, which releases at the next edge.
  - The lock timer increments every cycle the lock is held and clears on each owner accept.
  - At LOCK_MAX the lock is force-released, lock_abort is set, and it is cleared only by reset.
  - A lock request from the owner while locked re-arms the lock and the timer.
- Simultaneous events:
  - Lock release and a new request in the same cycle: the release takes effect at the edge, and arbitration is unlocked from the next cycle.
  - Starvation forcing never overrides a held lock.
- mem_en is 0 in any cycle that follows an edge with no accept.

Test Plan:
- Host only: port0 read addr 0x05, memory holds 0xA7 -> ready[0] same cycle; mem_en/addr=0x05 next cycle; rsp_valid=001, rsp_data=0xA7 two edges after accept.
- Fairness: ports 1 and 2 continuously valid, host idle -> grants alternate 1,2,1,2; rr pointer wraps 2->1.
- Starvation: host and port1 continuously valid, STARVE_LIMIT=12 -> port1 granted exactly once per 13 cycles; starve counter returns to 0 after the grant.
- Atomic write: port1 writes 0x04,0x05,0x06 with lock=1,1,0 while host requests -> host ready held low until edge after 0x06 accept; lock_owner 1 -> F.
- Lock timeout: port2 accepts with lock=1 then idles with lock high -> lock_owner=F and lock_abort=1 after 64 cycles; host granted the following cycle.
- Reset mid-read: reset asserted the cycle after accepting a port2 read -> rsp_valid stays 000; all outputs at reset values; lock_abort 0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one single-port synchronous register RAM among
// N_REQ requesters. Port 0 (host) has fixed priority, ports 1..N_REQ-1 are
// served round-robin, a starvation guard forces a low port through after the
// host has won STARVE_LIMIT times in a row, and a per-port lock gives atomic
// multi-byte sequences that time out after LOCK_MAX cycles.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   req_valid/we/lock  per-port request, write enable, keep-ownership flag
//   req_addr/wdata     per-port address and write data, packed by port index
//   req_ready          one-hot grant (combinational); accept = valid && ready
//   rsp_valid          one-hot read strobe, two edges after accept
//   rsp_data           read data, qualified by rsp_valid
//   mem_en/we/addr/wdata  registered RAM command
//   mem_rdata          RAM read data, valid one cycle after mem_en
//   lock_abort         sticky lock-timeout flag
//   lock_owner         current lock owner, 4'hF when unlocked
module regfile_arbiter #(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 12,
  parameter int unsigned LOCK_MAX     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       lock_abort,
  output logic [3:0]                 lock_owner
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LT_W  = $clog2(LOCK_MAX + 1);
  localparam logic [3:0]  NO_OWNER = 4'hF;

  logic [IDX_W-1:0]  rr_ptr;
  logic [SC_W-1:0]   starve_cnt;
  logic [LT_W-1:0]   lock_timer;
  logic [N_REQ-1:0]  rd_pend;

  logic              locked;
  logic              low_valid;
  logic              rr_found;
  logic [IDX_W-1:0]  rr_pick;
  logic              owner_valid;
  logic              owner_lock;
  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_host;
  logic              grant_low;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign locked    = (lock_owner != NO_OWNER);
  assign low_valid = |req_valid[N_REQ-1:1];

  // Round-robin pick: first valid low port at or above rr_ptr, else wrap to the lowest.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 1; i < N_REQ; i++) begin
      if (!rr_found && req_valid[i] && (IDX_W'(i) >= rr_ptr)) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'(i);
      end
    end
    for (int i = 1; i < N_REQ; i++) begin
      if (!rr_found && req_valid[i]) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'(i);
      end
    end
  end

  // Request and lock flag of the current lock owner.
  always_comb begin
    owner_valid = 1'b0;
    owner_lock  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (lock_owner == 4'(i)) begin
        owner_valid = req_valid[i];
        owner_lock  = req_lock[i];
      end
    end
  end

  // Grant priority: lock owner, forced low port, host, round-robin.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (locked) begin
      grant_any = owner_valid;
      grant_idx = lock_owner[IDX_W-1:0];
    end else if (low_valid && (starve_cnt >= SC_W'(STARVE_LIMIT))) begin
      grant_any = rr_found;
      grant_idx = rr_pick;
    end else if (req_valid[0]) begin
      grant_any = 1'b1;
      grant_idx = '0;
    end else begin
      grant_any = rr_found;
      grant_idx = rr_pick;
    end
  end

  assign grant_host = grant_any && (grant_idx == '0);
  assign grant_low  = grant_any && (grant_idx != '0);

  // One-hot ready and mux of the granted port's request fields.
  always_comb begin
    req_ready = '0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && (grant_idx == IDX_W'(i))) begin
        req_ready[i] = 1'b1;
        sel_we       = req_we[i];
        sel_lock     = req_lock[i];
        sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata    = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // The RAM presents read data one cycle after mem_en, exactly in the
  // response cycle, so it is forwarded rather than re-registered.
  assign rsp_data = mem_rdata;

  // Memory command, response pipeline, rr pointer, starvation and lock state.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_pend    <= '0;
      rsp_valid  <= '0;
      rr_ptr     <= IDX_W'(1);
      starve_cnt <= '0;
      lock_timer <= '0;
      lock_owner <= NO_OWNER;
      lock_abort <= 1'b0;
    end else begin
      mem_en  <= grant_any;
      mem_we  <= grant_any && sel_we;
      if (grant_any) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      rd_pend   <= (grant_any && !sel_we) ? req_ready : '0;
      rsp_valid <= rd_pend;

      if (grant_low) begin
        rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? IDX_W'(1) : grant_idx + IDX_W'(1);
      end

      if (grant_low) begin
        starve_cnt <= '0;
      end else if (grant_host && low_valid && !locked && (starve_cnt != '1)) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end

      // Only the owner can be granted while locked, so any accept here is the owner's.
      if (grant_any && sel_lock) begin
        lock_owner <= 4'(grant_idx);
        lock_timer <= '0;
      end else if (locked) begin
        if (grant_any || (!owner_valid && !owner_lock)) begin
          lock_owner <= NO_OWNER;
          lock_timer <= '0;
        end else if (lock_timer == LT_W'(LOCK_MAX - 1)) begin
          lock_owner <= NO_OWNER;
          lock_timer <= '0;
          lock_abort <= 1'b1;
        end else begin
          lock_timer <= lock_timer + LT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_regfile_arbiter;

  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SL = 12;
  localparam int LM = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            lock_abort;
  logic [3:0]      lock_owner;

  always #5 clk = ~clk;

  regfile_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_abort(lock_abort), .lock_owner(lock_owner)
  );

  function automatic logic [DW-1:0] ram_init(int a);
    return DW'(a * 37 + 238);
  endfunction

  // Single-port synchronous RAM attached to the arbiter.
  logic [DW-1:0] ram [128];
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 128; a++) ram[a] <= ram_init(a);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Requester-side state.
  logic          pend_v    [N];
  logic          pend_we   [N];
  logic          pend_lock [N];
  logic [AW-1:0] pend_addr [N];
  logic [DW-1:0] pend_wdata[N];
  logic          idle_lock [N];
  int            p_req     [N];
  int            p_lock    = 0;
  bit            rand_idle = 0;
  logic [N-1:0]  last_acc;

  // Reference model state.
  int            m_owner, m_timer, m_starve, m_rr, m_rd_port, m_rsp_port;
  bit            m_abort, m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd_data, m_rsp_data;
  logic [DW-1:0] shadow [128];

  function automatic logic [N-1:0] oh(int p);
    logic [N-1:0] one = 1;
    return (p < 0) ? '0 : (one << p);
  endfunction

  task automatic m_reset();
    m_owner = -1; m_timer = 0; m_starve = 0; m_rr = 1; m_abort = 0;
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
    m_rd_port = -1; m_rsp_port = -1;
  endtask

  function automatic int m_grant();
    int  pick = -1;
    bit  low  = |req_valid[N-1:1];
    if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N - 1; k++) begin
      int p = ((m_rr - 1 + k) % (N - 1)) + 1;
      if (pick < 0 && req_valid[p]) pick = p;
    end
    if (low && m_starve >= SL) return pick;
    if (req_valid[0]) return 0;
    return pick;
  endfunction

  task automatic m_step(int g);
    bit low = |req_valid[N-1:1];
    if (reset) begin
      m_reset();
      return;
    end
    m_rsp_port = m_rd_port;
    m_rsp_data = m_rd_data;
    m_rd_port  = -1;
    m_en       = (g >= 0);
    if (g >= 0) begin
      m_we    = req_we[g];
      m_addr  = req_addr[g*AW +: AW];
      m_wdata = req_wdata[g*DW +: DW];
      if (m_we) shadow[m_addr] = m_wdata;
      else begin
        m_rd_port = g;
        m_rd_data = shadow[m_addr];
      end
    end
    if (g >= 1) m_starve = 0;
    else if (g == 0 && low && m_owner < 0 && m_starve < SL) m_starve++;
    if (g >= 1) m_rr = (g == N - 1) ? 1 : g + 1;
    if (g >= 0 && req_lock[g]) begin
      m_owner = g; m_timer = 0;
    end else if (m_owner >= 0) begin
      if (g == m_owner || (!req_valid[m_owner] && !req_lock[m_owner])) begin
        m_owner = -1; m_timer = 0;
      end else if (m_timer + 1 >= LM) begin
        m_owner = -1; m_timer = 0; m_abort = 1;
      end else begin
        m_timer++;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend_v[i] && !reset;
      req_we[i]    = pend_we[i];
      req_lock[i]  = pend_v[i] ? pend_lock[i] : idle_lock[i];
      req_addr[i*AW +: AW]  = pend_addr[i];
      req_wdata[i*DW +: DW] = pend_wdata[i];
    end
  endtask

  task automatic gen();
    for (int i = 0; i < N; i++) begin
      if (!pend_v[i] && $urandom_range(99) < p_req[i]) begin
        pend_v[i]     = 1'b1;
        pend_we[i]    = 1'($urandom_range(1));
        pend_lock[i]  = ($urandom_range(99) < p_lock);
        pend_addr[i]  = AW'($urandom_range(15));
        pend_wdata[i] = DW'($urandom_range(255));
      end
      if (rand_idle && $urandom_range(4) == 0) idle_lock[i] = 1'($urandom_range(1));
    end
  endtask

  task automatic post(int p, bit we, bit lk, logic [AW-1:0] a, logic [DW-1:0] d);
    pend_v[p] = 1'b1; pend_we[p] = we; pend_lock[p] = lk;
    pend_addr[p] = a; pend_wdata[p] = d;
  endtask

  // One clock: drive, compare at negedge, advance model, retire accepts.
  task automatic cycle();
    int g;
    logic [N-1:0] acc;
    drive();
    @(negedge clk);
    g = m_grant();
    check_eq("req_ready", 32'(req_ready), 32'(oh(g)));
    check_eq("mem_en", 32'(mem_en), 32'(m_en));
    if (m_en) begin
      check_eq("mem_we", 32'(mem_we), 32'(m_we));
      check_eq("mem_addr", 32'(mem_addr), 32'(m_addr));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(oh(m_rsp_port)));
    if (m_rsp_port >= 0) check_eq("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
    check_eq("lock_owner", 32'(lock_owner), (m_owner < 0) ? 32'hF : 32'(m_owner));
    check_eq("lock_abort", 32'(lock_abort), 32'(m_abort));
    acc      = req_ready & req_valid;
    last_acc = acc;
    m_step(g);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) pend_v[i] = 1'b0;
    gen();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; idle_lock[i] = 1'b0;
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int first, cnt;
    bit host_won;
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 0; pend_we[i] = 0; pend_lock[i] = 0; pend_addr[i] = '0;
      pend_wdata[i] = '0; idle_lock[i] = 0; p_req[i] = 0;
    end
    reset = 1'b1;
    drive();
    @(posedge clk);
    #1;
    m_reset();
    for (int a = 0; a < 128; a++) shadow[a] = ram_init(a);
    check_eq("rst_owner", 32'(lock_owner), 32'hF);
    check_eq("rst_abort", 32'(lock_abort), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;

    // Host read of 0x05 holding 0xA7.
    post(0, 0, 0, 7'h05, 8'h00);
    cycle();
    check_eq("host_accept", 32'(last_acc), 32'b001);
    check_eq("host_mem_en", 32'(mem_en), 32'h1);
    check_eq("host_mem_addr", 32'(mem_addr), 32'h05);
    cycle();
    check_eq("host_rsp_valid", 32'(rsp_valid), 32'b001);
    check_eq("host_rsp_data", 32'(rsp_data), 32'hA7);

    // Fairness between ports 1 and 2.
    p_req[1] = 100; p_req[2] = 100;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle();
      check_eq("rr_alternate", 32'(last_acc), (k % 2 == 0) ? 32'b010 : 32'b100);
    end

    // Starvation guard: host and port 1 always valid.
    p_req[0] = 100; p_req[1] = 100; p_req[2] = 0;
    do_reset();
    first = 0; cnt = 0;
    for (int k = 1; k <= 39; k++) begin
      cycle();
      if (last_acc[1]) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    check_eq("starve_first", 32'(first), 32'd13);
    check_eq("starve_count", 32'(cnt), 32'd3);

    // Atomic three-byte write by port 1 while the host waits.
    for (int i = 0; i < N; i++) p_req[i] = 0;
    do_reset();
    post(1, 1, 1, 7'h04, 8'h11);
    cycle();
    check_eq("atomic_acc0", 32'(last_acc), 32'b010);
    check_eq("atomic_owner0", 32'(lock_owner), 32'h1);
    post(0, 0, 0, 7'h04, 8'h00);
    post(1, 1, 1, 7'h05, 8'h22);
    cycle();
    check_eq("atomic_acc1", 32'(last_acc), 32'b010);
    post(1, 1, 0, 7'h06, 8'h33);
    cycle();
    check_eq("atomic_acc2", 32'(last_acc), 32'b010);
    check_eq("atomic_release", 32'(lock_owner), 32'hF);
    cycle();
    check_eq("atomic_host", 32'(last_acc), 32'b001);
    cycle();
    check_eq("atomic_rdata", 32'(rsp_data), 32'h11);

    // Lock timeout: port 2 holds the lock while idle.
    do_reset();
    post(2, 0, 1, 7'h10, 8'h00);
    idle_lock[2] = 1'b1;
    cycle();
    check_eq("timeout_acc", 32'(last_acc), 32'b100);
    post(0, 0, 0, 7'h05, 8'h00);
    host_won = 0;
    for (int k = 1; k < LM; k++) begin
      cycle();
      if (last_acc[0]) host_won = 1;
    end
    check_eq("timeout_hold", 32'(lock_owner), 32'h2);
    check_eq("timeout_blocked", 32'(host_won), 32'h0);
    cycle();
    check_eq("timeout_owner", 32'(lock_owner), 32'hF);
    check_eq("timeout_abort", 32'(lock_abort), 32'h1);
    cycle();
    check_eq("timeout_host", 32'(last_acc), 32'b001);
    idle_lock[2] = 1'b0;

    // Reset one cycle after accepting a port 2 read.
    post(2, 0, 0, 7'h07, 8'h00);
    cycle();
    check_eq("rstrd_acc", 32'(last_acc), 32'b100);
    reset = 1'b1;
    cycle();
    check_eq("rstrd_rsp", 32'(rsp_valid), 32'h0);
    check_eq("rstrd_mem_en", 32'(mem_en), 32'h0);
    check_eq("rstrd_abort", 32'(lock_abort), 32'h0);
    check_eq("rstrd_owner", 32'(lock_owner), 32'hF);
    reset = 1'b0;
    cycle();
    check_eq("rstrd_rsp2", 32'(rsp_valid), 32'h0);

    // Randomized traffic with locks and occasional resets.
    p_req[0] = 60; p_req[1] = 50; p_req[2] = 50;
    p_lock = 15; rand_idle = 1;
    for (int k = 0; k < 4000; k++) begin
      reset = ($urandom_range(999) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
